mux_scan_sequencer: RTL and testbench

//   Control stage that sits around the 4:1 mux. Drives the mux select lines {s1,s0}

---
 rtl/mux_scan_sequencer_pkg.sv | 7 +
 rtl/mux_scan_sequencer_if.sv | 10 +
 rtl/mux_scan_sequencer_dwell_ctr.sv | 22 ++
 rtl/mux_scan_sequencer.sv | 69 ++++++
 tb/tb_mux_scan_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_pkg: shared state encoding and parameter limits for the mux scan sequencer
package mux_scan_pkg;
    typedef logic state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SCAN = 1'b1;
    localparam int DWELL_MIN = 1;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: valid/ready frame stream carrying one sample bit per channel
interface mux_scan_sequencer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sample_out;
    logic            valid;
    logic            ready;
    modport master(output sample_out, valid, input ready);
    modport slave(input sample_out, valid, output ready);
endinterface

// File: rtl/mux_scan_sequencer_dwell_ctr.sv
// mux_scan_dwell_ctr: loadable down-counter that times how long each select value is held
module mux_scan_dwell_ctr
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int D = DWELL < DWELL_MIN ? DWELL_MIN : DWELL;
    localparam int W = D > 1 ? $clog2(D) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= W'(D - 1);
        else if (en && !zero) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: sweeps the mux select lines and emits one sampled frame per sweep
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 y_in,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 overrun,
    mux_scan_sequencer_if.master stream
);
    localparam int N_CH = 2 ** SEL_W;
    state_t state, state_d;
    logic [SEL_W-1:0] sel_d;
    logic [N_CH-2:0] shadow, shadow_d;
    logic [N_CH-1:0] sample, sample_d;
    logic valid, valid_d, busy_d, overrun_d;
    logic zero, load, go, last, step, frame_end, scan;
    assign scan = state == ST_SCAN;
    assign go = !scan && start;
    assign last = sel == SEL_W'(N_CH - 1);
    assign step = scan && zero && !last;
    assign frame_end = scan && zero && last;
    assign load = go || step || (frame_end && continuous);
    mux_scan_dwell_ctr #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .en   (scan),
        .zero (zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= '0;
            shadow  <= '0;
            sample  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            shadow  <= shadow_d;
            sample  <= sample_d;
            valid   <= valid_d;
            busy    <= busy_d;
            overrun <= overrun_d;
        end
    end
    always_comb state_d = !scan ? (start ? ST_SCAN : ST_IDLE) : (frame_end && !continuous ? ST_IDLE : ST_SCAN);
    // A frame landing on the accepting edge keeps valid high without flagging overrun
    always_comb begin
        sel_d = go || frame_end ? '0 : step ? sel + SEL_W'(1) : sel;
        for (int k = 0; k < N_CH - 1; k++) shadow_d[k] = step && sel == SEL_W'(k) ? y_in : shadow[k];
        sample_d = frame_end ? {y_in, shadow} : sample;
        valid_d = frame_end || (valid && !stream.ready);
        busy_d = !scan ? start : !(frame_end && !continuous);
        overrun_d = !go && (overrun || (frame_end && valid && !stream.ready));
    end
    assign stream.sample_out = sample;
    assign stream.valid = valid;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: mux-in-the-loop bench with a cycle-index model and directed frame checks
module tb_mux_scan_sequencer;
    localparam int N = 4;
    localparam int D = 2;
    logic clk = 0, rst_n = 0, start = 0, continuous = 0, ready = 0;
    logic start1 = 0, start5 = 0, ready_x = 1, cont_x = 0;
    logic [3:0] i_vec = '0;
    logic [1:0] sel, sel1, sel5;
    logic busy, overrun, busy1, ovr1, busy5, ovr5, y, y1, y5;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.N_CH(4)) bus ();
    mux_scan_sequencer_if #(.N_CH(4)) bus1 ();
    mux_scan_sequencer_if #(.N_CH(4)) bus5 ();
    assign bus.ready = ready;
    assign bus1.ready = ready_x;
    assign bus5.ready = ready_x;
    assign y = i_vec[sel];
    assign y1 = i_vec[sel1];
    assign y5 = i_vec[sel5];

    mux_scan_sequencer #(.SEL_W(2), .DWELL(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .y_in(y),
        .sel(sel), .busy(busy), .overrun(overrun), .stream(bus.master));
    mux_scan_sequencer #(.SEL_W(2), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont_x), .y_in(y1),
        .sel(sel1), .busy(busy1), .overrun(ovr1), .stream(bus1.master));
    mux_scan_sequencer #(.SEL_W(2), .DWELL(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .continuous(cont_x), .y_in(y5),
        .sel(sel5), .busy(busy5), .overrun(ovr5), .stream(bus5.master));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sweep is N*D edges indexed by t; channel t/D is sampled on its last dwell edge
    int m_t = 0;
    logic m_busy = 0, m_valid = 0, m_ovr = 0;
    logic [3:0] m_bits = '0, m_sample = '0;

    task automatic model_step();
        logic fe, acc;
        if (!rst_n) begin
            m_t = 0; m_busy = 0; m_valid = 0; m_ovr = 0; m_bits = '0; m_sample = '0;
            return;
        end
        fe = 0;
        acc = m_valid && ready;
        if (!m_busy) begin
            if (start) begin m_busy = 1; m_t = 0; m_ovr = 0; end
        end else begin
            if (m_t % D == D - 1) m_bits[m_t / D] = i_vec[m_t / D];
            if (m_t == N * D - 1) begin fe = 1; m_t = 0; m_busy = continuous; end
            else m_t++;
        end
        if (fe) begin
            if (m_valid && !ready) m_ovr = 1;
            m_sample = m_bits;
            m_valid = 1;
        end else if (acc) m_valid = 0;
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always begin
        @(posedge clk);
        #1;
        check("model_sel", 32'(sel), m_busy ? 32'(m_t / D) : 0);
        check("model_sample", 32'(bus.sample_out), 32'(m_sample));
        check("model_valid", 32'(bus.valid), 32'(m_valid));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = -1;
        for (int c = 1; c <= lim; c++) begin
            tick();
            if (bus.valid) begin n = c; break; end
        end
    endtask

    initial begin
        int n, n1, n5;
        logic [3:0] s1, s5;
        // 1. reset held while start toggles
        repeat (4) begin
            start = ~start;
            tick();
            check("reset_outputs", 32'({sel, bus.sample_out, bus.valid, busy, overrun}), 0);
        end
        start = 0;
        rst_n = 1;
        tick();
        // 2. single shot
        i_vec = 4'b1010;
        ready = 1;
        pulse_start();
        check("ss_busy_start", 32'(busy), 1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) check("ss_sel_e2", 32'(sel), 1);
            if (k == 4) check("ss_sel_e4", 32'(sel), 2);
            if (k == 6) check("ss_sel_e6", 32'(sel), 3);
            if (k < 8) check("ss_valid_early", 32'(bus.valid), 0);
            if (k == 8) begin
                check("ss_valid_e8", 32'(bus.valid), 1);
                check("ss_sample", 32'(bus.sample_out), 32'b1010);
                check("ss_busy_end", 32'(busy), 0);
            end
            if (k == 9) check("ss_valid_e9", 32'(bus.valid), 0);
        end
        // 3. backpressure and overrun
        continuous = 1;
        ready = 0;
        i_vec = 4'b0110;
        pulse_start();
        repeat (8) tick();
        check("bp_valid_f1", 32'(bus.valid), 1);
        check("bp_sample_f1", 32'(bus.sample_out), 32'b0110);
        check("bp_ovr_f1", 32'(overrun), 0);
        i_vec = 4'b1001;
        repeat (4) tick();
        check("bp_hold", 32'(bus.sample_out), 32'b0110);
        repeat (4) tick();
        check("bp_sample_f2", 32'(bus.sample_out), 32'b1001);
        check("bp_ovr_f2", 32'(overrun), 1);
        continuous = 0;
        repeat (9) tick();
        check("bp_idle", 32'(busy), 0);
        ready = 1;
        tick();
        check("bp_consumed", 32'(bus.valid), 0);
        check("bp_ovr_sticky", 32'(overrun), 1);
        pulse_start();
        check("bp_ovr_cleared", 32'(overrun), 0);
        repeat (9) tick();
        // 4. all i-vectors
        for (int v = 0; v < 16; v++) begin
            i_vec = 4'(v);
            pulse_start();
            wait_valid(12, n);
            check("sweep_latency", 32'(n), 8);
            check("sweep_sample", 32'(bus.sample_out), 32'(v));
            tick();
        end
        // 5a. start while busy
        i_vec = 4'b0011;
        pulse_start();
        repeat (4) tick();
        check("mid_sel2", 32'(sel), 2);
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        check("mid_start_valid", 32'(bus.valid), 1);
        check("mid_start_sample", 32'(bus.sample_out), 32'b0011);
        tick();
        check("mid_start_norestart", 32'(busy), 0);
        // 5b. continuous dropped mid-sweep
        continuous = 1;
        i_vec = 4'b1100;
        pulse_start();
        repeat (2) tick();
        check("drop_sel1", 32'(sel), 1);
        continuous = 0;
        repeat (6) tick();
        check("drop_valid", 32'(bus.valid), 1);
        check("drop_sample", 32'(bus.sample_out), 32'b1100);
        check("drop_busy", 32'(busy), 0);
        repeat (2) tick();
        check("drop_idle", 32'({busy, sel}), 0);
        // 5c. reset mid-sweep
        i_vec = 4'b0101;
        pulse_start();
        repeat (4) tick();
        check("rst_sel2", 32'(sel), 2);
        rst_n = 0;
        #1;
        check("rst_async", 32'({sel, bus.sample_out, bus.valid, busy, overrun}), 0);
        tick();
        rst_n = 1;
        repeat (12) begin
            tick();
            check("rst_no_valid", 32'({bus.valid, busy}), 0);
        end
        // 6. DWELL=1 and DWELL=5 builds
        i_vec = 4'b1101;
        start1 = 1;
        start5 = 1;
        tick();
        start1 = 0;
        start5 = 0;
        n1 = -1;
        n5 = -1;
        s1 = '0;
        s5 = '0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (bus1.valid && n1 < 0) begin n1 = c; s1 = bus1.sample_out; end
            if (bus5.valid && n5 < 0) begin n5 = c; s5 = bus5.sample_out; end
        end
        check("dwell1_latency", 32'(n1), 4);
        check("dwell1_sample", 32'(s1), 32'b1101);
        check("dwell5_latency", 32'(n5), 20);
        check("dwell5_sample", 32'(s5), 32'b1101);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
